// File: rtl/pwm_spd_if.sv
// Bundles the PWM pair, error clear and decoded speed outputs of one motor
// channel. The master drives the PWM pair; the decoder is the slave.
interface pwm_spd_if;
  logic               PWM1;
  logic               PWM2;
  logic               clr_err;
  logic signed [10:0] spd;
  logic               vld;
  logic               period_err;
  logic               stall;
  logic               shoot_thru;

  modport master (
    output PWM1, PWM2, clr_err,
    input  spd, vld, period_err, stall, shoot_thru
  );

  modport slave (
    input  PWM1, PWM2, clr_err,
    output spd, vld, period_err, stall, shoot_thru
  );
endinterface

// File: rtl/pwm_spd_decoder.sv
// pwm_spd_decoder: recovers the signed 11-bit speed command from a
// complementary PWM pair by counting high cycles per PWM period.
// Also flags period errors, stalls (no rising edge for 2*PERIOD cycles)
// and sticky shoot-through (both PWM inputs high together).
// Build option: PWM_DEC_SYNC_EN adds a 2-flop synchronizer on PWM1/PWM2
// ahead of the sampling register (2 extra cycles of latency).
module pwm_spd_decoder #(
  parameter int unsigned PERIOD = 2048
) (
  input logic       clk,
  input logic       rst,
  pwm_spd_if.slave  bus
);

  localparam int unsigned CW = $clog2(PERIOD) + 2;
  localparam logic [CW-1:0] MID_C  = CW'(PERIOD / 2);
  localparam logic [CW-1:0] PER_C  = CW'(PERIOD);
  localparam logic [CW-1:0] PER2_C = CW'(2 * PERIOD);
  localparam logic [CW-1:0] PER2_M1_C = CW'(2 * PERIOD - 1);

  typedef enum logic {
    SYNC,
    MEAS
  } state_t;

  // Saturate a CW-bit two's-complement difference to [-1024, +1023].
  function automatic logic signed [10:0] sat11(input logic [CW-1:0] diff);
    logic signed [CW-1:0] s;
    s = signed'(diff);
    if (s > 1023)
      return 11'sh3FF;
    else if (s < -1024)
      return 11'sh400;
    else
      return 11'(s);
  endfunction

  logic p1_in;
  logic p2_in;

`ifdef PWM_DEC_SYNC_EN
  logic [1:0] p1_m_q, p1_m_d;
  logic [1:0] p2_m_q, p2_m_d;

  // Shift the raw inputs into the two-stage synchronizers.
  always_comb begin
    p1_m_d = {p1_m_q[0], bus.PWM1};
    p2_m_d = {p2_m_q[0], bus.PWM2};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_m_q <= '0;
      p2_m_q <= '0;
    end else begin
      p1_m_q <= p1_m_d;
      p2_m_q <= p2_m_d;
    end
  end

  assign p1_in = p1_m_q[1];
  assign p2_in = p2_m_q[1];
`else
  assign p1_in = bus.PWM1;
  assign p2_in = bus.PWM2;
`endif

  state_t             state_q, state_d;
  logic               p1_s_q, p1_s_d;
  logic               p2_s_q, p2_s_d;
  logic               p1_d_q, p1_d_d;
  logic [CW-1:0]      hi_cnt_q, hi_cnt_d;
  logic [CW-1:0]      per_cnt_q, per_cnt_d;
  logic signed [10:0] spd_q, spd_d;
  logic               vld_q, vld_d;
  logic               period_err_q, period_err_d;
  logic               stall_q, stall_d;
  logic               shoot_thru_q, shoot_thru_d;
  logic               rise;

  assign rise = p1_s_q & ~p1_d_q;

  // Sampling, edge detection, measurement FSM and flag updates.
  always_comb begin
    p1_s_d       = p1_in;
    p2_s_d       = p2_in;
    p1_d_d       = p1_s_q;
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    per_cnt_d    = per_cnt_q;
    spd_d        = spd_q;
    vld_d        = 1'b0;
    period_err_d = period_err_q;
    stall_d      = stall_q;
    // Set has priority over clear when both land in the same cycle.
    shoot_thru_d = (shoot_thru_q & ~bus.clr_err) | (p1_s_q & p2_s_q);

    case (state_q)
      SYNC: begin
        hi_cnt_d  = '0;
        per_cnt_d = '0;
        if (rise) begin
          state_d   = MEAS;
          hi_cnt_d  = CW'(1);
          per_cnt_d = CW'(1);
        end
      end

      MEAS: begin
        if (rise) begin
          // The rise cycle itself is the first high cycle of the new period.
          spd_d        = sat11(hi_cnt_q - MID_C);
          period_err_d = (per_cnt_q != PER_C);
          vld_d        = 1'b1;
          stall_d      = 1'b0;
          hi_cnt_d     = CW'(1);
          per_cnt_d    = CW'(1);
        end else if (per_cnt_q != PER2_C) begin
          per_cnt_d = per_cnt_q + CW'(1);
          hi_cnt_d  = hi_cnt_q + CW'(p1_s_q);
          // Timeout reports once, on the step into saturation; afterwards
          // both counters freeze until the next rise.
          if (per_cnt_q == PER2_M1_C) begin
            stall_d      = 1'b1;
            vld_d        = 1'b1;
            period_err_d = 1'b1;
            spd_d        = p1_s_q ? 11'sh3FF : 11'sh400;
          end
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SYNC;
      p1_s_q       <= 1'b0;
      p2_s_q       <= 1'b0;
      p1_d_q       <= 1'b0;
      hi_cnt_q     <= '0;
      per_cnt_q    <= '0;
      spd_q        <= '0;
      vld_q        <= 1'b0;
      period_err_q <= 1'b0;
      stall_q      <= 1'b0;
      shoot_thru_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p1_s_q       <= p1_s_d;
      p2_s_q       <= p2_s_d;
      p1_d_q       <= p1_d_d;
      hi_cnt_q     <= hi_cnt_d;
      per_cnt_q    <= per_cnt_d;
      spd_q        <= spd_d;
      vld_q        <= vld_d;
      period_err_q <= period_err_d;
      stall_q      <= stall_d;
      shoot_thru_q <= shoot_thru_d;
    end
  end

  assign bus.spd        = spd_q;
  assign bus.vld        = vld_q;
  assign bus.period_err = period_err_q;
  assign bus.stall      = stall_q;
  assign bus.shoot_thru = shoot_thru_q;

endmodule

// File: tb/tb_pwm_spd_decoder.sv
// Scoreboard bench for pwm_spd_decoder: stimulus pushes the expected
// measurement for each PWM period; a monitor pops and compares on every vld.
module tb_pwm_spd_decoder;

`ifdef PWM_DEC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  pwm_spd_if bus ();

  pwm_spd_decoder #(.PERIOD(2048)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [10:0] spd;
    logic               err;
    logic               stall;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int s, input bit e, input bit st);
    exp_t x;
    x.spd   = 11'(s);
    x.err   = e;
    x.stall = st;
    q.push_back(x);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_spd"},   int'(bus.spd),     0);
    chk({tag, "_vld"},   int'(bus.vld),     0);
    chk({tag, "_perr"},  int'(bus.period_err), 0);
    chk({tag, "_stall"}, int'(bus.stall),   0);
    chk({tag, "_shoot"}, int'(bus.shoot_thru), 0);
  endtask

  // Monitor: every vld must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && bus.vld) begin
      if (q.size() == 0) begin
        chk("unexpected_vld", 1, 0);
      end else begin
        x = q.pop_front();
        chk("spd",        int'(bus.spd),        int'(x.spd));
        chk("period_err", int'(bus.period_err), int'(x.err));
        chk("stall",      int'(bus.stall),      int'(x.stall));
      end
    end
  end

  // One PWM period: hi cycles high, per-hi low. Optional one-cycle overlap
  // on the first cycle and an optional clr_err pulse in the low phase.
  task automatic period(input int hi, input int per, input bit do_push,
                        input bit ov, input bit clr);
    if (do_push) push(hi - 1024, per != 2048, 1'b0);
    for (int i = 0; i < per; i++) begin
      bus.PWM1    = (i < hi);
      bus.PWM2    = ~(i < hi) | (ov && i == 0);
      bus.clr_err = clr && (i == hi + 10);
      @(posedge clk);
      #1;
      if (clr && i == hi + 10) chk("shoot_clr", int'(bus.shoot_thru), 0);
    end
    bus.clr_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.PWM1    = 1'b0;
    bus.PWM2    = 1'b1;
    bus.clr_err = 1'b0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    repeat (3) period(1024, 2048, 1, 0, 0);
    chk("shoot_idle", int'(bus.shoot_thru), 0);
    period(1536, 2048, 1, 0, 0);
    period(256,  2048, 1, 0, 0);
    period(2047, 2048, 1, 0, 0);
    period(1000, 2000, 1, 0, 0);
    period(1024, 2048, 1, 0, 0);

    // PWM1 stuck high 5000 cycles: one timeout report, then the next rise
    // reports the frozen counters (4096 high of 4096).
    push(1023, 1'b1, 1'b1);
    push(1023, 1'b1, 1'b0);
    for (int i = 0; i < 5000; i++) begin
      bus.PWM1 = 1'b1;
      bus.PWM2 = 1'b0;
      @(posedge clk);
      #1;
      if (i == 4094 + LAT) chk("stall_early", int'(bus.stall), 0);
      if (i == 4095 + LAT) chk("stall_set",   int'(bus.stall), 1);
    end
    for (int i = 0; i < 1000; i++) begin
      bus.PWM1 = 1'b0;
      bus.PWM2 = 1'b1;
      @(posedge clk);
      #1;
    end

    // Shoot-through: set by one overlap cycle, sticky, cleared by clr_err.
    period(1024, 2048, 1, 1, 0);
    chk("shoot_set", int'(bus.shoot_thru), 1);
    repeat (5) period(1024, 2048, 1, 0, 0);
    chk("shoot_hold", int'(bus.shoot_thru), 1);
    period(1024, 2048, 1, 0, 1);

    // Reset 700 cycles into a period; the period is discarded.
    for (int i = 0; i < 700; i++) begin
      bus.PWM1 = (i < 512);
      bus.PWM2 = ~(i < 512);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 1348; i++) begin
      bus.PWM1 = 1'b0;
      bus.PWM2 = 1'b1;
      @(posedge clk);
      #1;
    end
    period(1536, 2048, 1, 0, 0);
    period(1024, 2048, 1, 0, 0);
    period(1024, 2048, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_spd_decoder.md
# pwm_spd_decoder

Recovers the signed 11-bit speed command from one motor's complementary PWM pair (PWM1/PWM2) as produced by the motor driver. It measures high time per PWM period, re-centres it around mid-scale, and flags period errors, stalls and shoot-through. It serves as the receive-side model in motor-path testbenches and as an on-chip loop-back monitor. Instantiate one per motor.

## Interface
- PERIOD, 2048: PWM period in clk cycles; power of 2, 64..4096; MID = PERIOD/2.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- PWM1  in  1  high-side PWM input (duty carries speed)
- PWM2  in  1  low-side PWM input (complement plus deadtime)
- clr_err  in  1  synchronous clear of sticky error flags
- spd  out  11  signed recovered speed, two's complement
- vld  out  1  one-cycle pulse: spd updated
- period_err  out  1  last measured period != PERIOD (updated with vld)
- stall  out  1  no PWM1 rising edge for 2*PERIOD cycles
- shoot_thru  out  1  sticky: PWM1 and PWM2 sampled high together

## Operation
- Inputs pass through the sampling stage (see Configuration), then a 1-flop edge detector: rise = p1_s & ~p1_d.
- FSM states: SYNC (after reset, wait for first rise), MEAS (count within period).
- SYNC: counters held at 0; on rise -> MEAS, hi_cnt=1, per_cnt=1; no vld.
- MEAS, non-rise cycle: per_cnt += 1 (saturate at 2*PERIOD); hi_cnt += p1_s.
- MEAS, rise cycle: latch spd = sat11(hi_cnt - MID), period_err = (per_cnt != PERIOD), pulse vld; reload hi_cnt=1, per_cnt=1; clear stall.
- Widths: hi_cnt and per_cnt are clog2(PERIOD)+2 bits; subtraction done signed at that width, then saturated to [-1024, +1023].
- Timeout: per_cnt reaching 2*PERIOD in MEAS -> stall=1, spd = +1023 if p1_s high else -1024, vld pulses once, period_err=1; state stays MEAS, counters held until next rise.
- shoot_thru: set on any cycle with p1_s & p2_s; cleared only by clr_err (set wins if both occur same cycle).
- PWM2 is checked only for overlap; it does not feed the speed measurement.

## Timing
- Reset values: spd=0, vld=0, period_err=0, stall=0, shoot_thru=0, state=SYNC, counters 0.
- Latency: vld asserts the cycle after the clk edge that registers the rise; spd/period_err valid the same cycle as vld and hold until the next update.
- First vld after reset needs two PWM1 rising edges (first only arms).
- Reset mid-period: all state discarded immediately (async); measurement restarts from SYNC.
- Rise coincident with timeout: rise wins (normal measurement, stall stays 0).
- 0% or 100% duty (no edges) handled only by timeout path.
- Full-scale duty: hi_cnt = PERIOD -> spd saturates to +1023.

## Configuration
- PWM_DEC_SYNC_EN defined: PWM1 and PWM2 each pass through a 2-flop metastability synchronizer before the edge detector; adds 2 cycles to vld latency relative to the input edge; synchronizer flops reset to 0.
- Undefined: single register stage only (inputs assumed synchronous to clk); baseline latency.
- Measured values (spd, period_err) identical in both builds; only absolute timing shifts.

## Test plan
- rst 1->0, PWM1 high 1024 of every 2048 cycles, PWM2 = ~PWM1 -> from second rise on, vld every 2048 cycles, spd=0x000, period_err=0.
- PWM1 high 1536/2048 -> spd=0x200 (+512); high 256/2048 -> spd=0x500 (-768); high 2047/2048 -> spd=0x3FF.
- PWM1 held high 5000 cycles after a valid period -> stall=1 at 4096 cycles past last rise, spd=0x3FF, single vld, period_err=1; next rise clears stall.
- PWM1 period 2000 cycles, high 1000 -> period_err=1, spd=0x3E8-0x400 = 0x7E8 (-24).
- PWM1 and PWM2 both high for 1 cycle -> shoot_thru=1 and stays 1 for 10000 cycles; clr_err pulse -> 0 next cycle.
- Assert rst for 1 cycle 700 cycles into a period -> all outputs 0 immediately; no vld until two further rises; both macro builds give equal spd sequences.
